seg_scan: RTL
=============

# seg_scan

Time-multiplexed scan controller for the multi-digit seven-segment display. It accepts a packed hex value, a per-digit blank mask and a leading-zero option over a valid/ready handshake. It steps through the digits at a programmable slot rate and presents one 4-bit nibble per slot to the downstream hex-to-segment decoder, together with a one-hot digit enable. New values are applied only at frame boundaries, so a displayed frame never mixes old and new data.

## Interface
- DIGITS, 8, number of display digits; digit 0 is least significant; legal range 2..16
- DIV, 50000, clock cycles per digit slot; legal minimum 2
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream offers a new display value
- in_ready  out  1  block can accept a value (= pending slot empty)
- in_data  in  4*DIGITS  packed nibbles, digit i at [4i+3:4i]
- in_blank  in  DIGITS  per-digit force-blank mask, 1 = digit dark
- in_lz  in  1  leading-zero suppression enable for this value
- seg_data  out  4  nibble for the current slot, to decoder data input
- seg_on  out  1  current digit is lit
- dig_sel  out  DIGITS  one-hot digit enable, active-high; all-zero when the current digit is dark
- frame_done  out  1  one-cycle pulse at the start of each frame

## Operation
- Internal state:
  - div_cnt: 0..DIV-1
  - dig_idx: 0..DIGITS-1
  - display regs: data, blank, lz
  - pending regs: data, blank, lz, plus pend_valid
- Prescaler: div_cnt increments every cycle and wraps at DIV-1. On wrap, dig_idx increments and wraps DIGITS-1 -> 0.
- Boundary cycle: div_cnt==DIV-1 and dig_idx==DIGITS-1.
- Handshake:
  - in_ready = ~pend_valid (combinational).
  - Transfer happens when in_valid && in_ready at a rising edge: pending regs capture in_data/in_blank/in_lz and pend_valid is set.
  - in_data must be held stable while in_valid is high and in_ready is low.
- Frame update:
  - On the boundary-cycle edge with pend_valid=1, pending regs are copied to the display regs and pend_valid is cleared.
  - A transfer on the boundary cycle itself goes to pending only. It is displayed at the next boundary.
- Leading-zero suppression: digit i is lz-dark when display lz=1 and display nibbles DIGITS-1 down to i are all 0. Digit 0 is never lz-dark, so value 0 shows a single "0".
- Lit rule: lit = ~blank[dig_idx] & ~lzdark[dig_idx].
- Outputs (combinational from registered state):
  - seg_on = lit
  - seg_data = lit ? nibble[dig_idx] : 4'h0
  - dig_sel = lit ? (1 << dig_idx) : 0
- frame_done: registered. High for the one cycle after each boundary edge, i.e. while dig_idx==0 and div_cnt==0.

## Timing
- Reset (asynchronous assert, synchronous release via clk):
  - div_cnt=0, dig_idx=0, pend_valid=0
  - display data=0, display blank=all-1, display lz=0
- Output values during and immediately after reset:
  - seg_on=0, seg_data=0, dig_sel=0, frame_done=0, in_ready=1
- Slot length is exactly DIV cycles. Frame length is DIGITS*DIV cycles. Scanning runs continuously from reset release.
- Latency from accept to display:
  - Accept at cycle A becomes visible at the first boundary edge strictly after A.
  - That is at most DIGITS*DIV cycles and at least 1 cycle (accept one cycle before the boundary).
- in_ready falls the cycle after an accept. It rises in the same cycle that frame_done is high, if pending was transferred. At most one value per frame is accepted.
- Reset mid-frame aborts the scan and discards any pending value. The display goes dark until the first frame boundary after a new accept.
- in_blank/in_lz take effect only with their data; changing them without a handshake has no effect.

## Test plan
- Reset check (DIGITS=4, DIV=4): hold rst_n=0, then release -> dig_sel=0, seg_on=0, in_ready=1. First frame_done occurs 16 cycles after release; display stays dark.
- Basic scan: accept in_data=16'h12AF, in_blank=0, in_lz=0 -> from the next frame, seg_data sequence F,A,2,1 with 4 cycles each, and dig_sel 0001,0010,0100,1000.
- Leading zero: accept in_data=16'h0030, in_lz=1 -> digits 3 and 2 dark (dig_sel=0, seg_on=0), digit 1 shows 3, digit 0 shows 0. A second case with value 16'h0000 shows only digit 0 = 0.
- Force blank: accept in_data=16'h5678, in_blank=4'b0100 -> digit 2 dark in every frame; other digits show 8,7,5.
- Back-pressure: accept in_data=16'h1111, then hold in_valid=1 with 16'h2222 -> in_ready stays 0 until frame_done. 16'h2222 is accepted that cycle and displayed one frame later; no frame contains mixed nibbles.
- Boundary accept and mid-frame reset: accept exactly on the boundary cycle -> value is not shown at the following frame_done but at the next one. Asserting rst_n=0 mid-frame with pending set -> pending is lost and outputs are immediately 0.

Source files
------------

// File: rtl/seg_scan_if.sv
// seg_scan_if: upstream value handshake and per-slot scan outputs of seg_scan
interface seg_scan_if #(parameter int DIGITS = 8);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   in_data;
  logic [DIGITS-1:0]     in_blank;
  logic                  in_lz;
  logic [3:0]            seg_data;
  logic                  seg_on;
  logic [DIGITS-1:0]     dig_sel;
  logic                  frame_done;
  modport master (output in_valid, in_data, in_blank, in_lz,
                  input  in_ready, seg_data, seg_on, dig_sel, frame_done);
  modport slave  (input  in_valid, in_data, in_blank, in_lz,
                  output in_ready, seg_data, seg_on, dig_sel, frame_done);
endinterface

// File: rtl/seg_scan.sv
// seg_scan: multiplexed seven-segment scanner, new values swapped in only at frame boundaries
module seg_scan #(
  parameter int DIGITS = 8,
  parameter int DIV    = 50000
) (
  input logic      clk,
  input logic      rst_n,
  seg_scan_if.slave bus
);
  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(DIGITS);
  logic [CW-1:0]         div_cnt_q, div_cnt_d;
  logic [IW-1:0]         dig_idx_q, dig_idx_d;
  logic [4*DIGITS-1:0]   dat_q, dat_d, pdat_q, pdat_d;
  logic [DIGITS-1:0]     blk_q, blk_d, pblk_q, pblk_d;
  logic                  lz_q, lz_d, plz_q, plz_d, pend_q, pend_d, fd_q, fd_d;
  logic                  wrap, bnd, acc, upd, allz, lit;
  logic [DIGITS-1:0]     lzd;
  always_comb begin
    wrap      = div_cnt_q == CW'(DIV - 1);
    bnd       = wrap && dig_idx_q == IW'(DIGITS - 1);
    acc       = bus.in_valid && !pend_q;
    upd       = bnd && pend_q;
    div_cnt_d = wrap ? '0 : div_cnt_q + 1'b1;
    dig_idx_d = wrap ? (bnd ? '0 : dig_idx_q + 1'b1) : dig_idx_q;
    pend_d    = acc | (pend_q & ~bnd);
    pdat_d    = acc ? bus.in_data : pdat_q;
    pblk_d    = acc ? bus.in_blank : pblk_q;
    plz_d     = acc ? bus.in_lz : plz_q;
    dat_d     = upd ? pdat_q : dat_q;
    blk_d     = upd ? pblk_q : blk_q;
    lz_d      = upd ? plz_q : lz_q;
    fd_d      = bnd;
  end
  // a digit is lz-dark when it and every more significant nibble are zero
  always_comb begin
    allz = 1'b1;
    lzd  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      allz   = allz & (dat_q[4*i +: 4] == 4'h0);
      lzd[i] = lz_q & allz & (i != 0);
    end
    lit = ~blk_q[dig_idx_q] & ~lzd[dig_idx_q];
  end
  assign bus.in_ready   = ~pend_q;
  assign bus.seg_on     = lit;
  assign bus.seg_data   = lit ? dat_q[{dig_idx_q, 2'b00} +: 4] : 4'h0;
  assign bus.dig_sel    = lit ? DIGITS'(1) << dig_idx_q : '0;
  assign bus.frame_done = fd_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      dig_idx_q <= '0;
      dat_q     <= '0;
      blk_q     <= '1;
      lz_q      <= 1'b0;
      pdat_q    <= '0;
      pblk_q    <= '0;
      plz_q     <= 1'b0;
      pend_q    <= 1'b0;
      fd_q      <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      dig_idx_q <= dig_idx_d;
      dat_q     <= dat_d;
      blk_q     <= blk_d;
      lz_q      <= lz_d;
      pdat_q    <= pdat_d;
      pblk_q    <= pblk_d;
      plz_q     <= plz_d;
      pend_q    <= pend_d;
      fd_q      <= fd_d;
    end
  end
endmodule
